// File: rtl/perf_counter_ctrl.sv
// perf_counter_ctrl: event counters with inhibit control, accessed through a two-state CSR handshake.
// Define RSD_PERF_COUNTER_OVERFLOW_IRQ_EN to build the sticky overflow vector and the perfIrq output.
module perf_counter_ctrl #(
  parameter int NUM_COUNTERS  = 4,
  parameter int COUNTER_WIDTH = 64,
  parameter int EVENT_WIDTH   = 2,
  parameter int ADDR_WIDTH    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [EVENT_WIDTH-1:0]   evCount [NUM_COUNTERS],
  input  logic                     csrReq,
  input  logic                     csrWe,
  input  logic [ADDR_WIDTH-1:0]    csrAddr,
  input  logic [COUNTER_WIDTH-1:0] csrWData,
  output logic                     csrAck,
  output logic [COUNTER_WIDTH-1:0] csrRData,
  output logic                     csrErr,
  output logic                     perfIrq
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  state_e                   state_q;
  logic                     ack_q;
  logic                     err_q;
  logic [COUNTER_WIDTH-1:0] rdata_q;
  logic [NUM_COUNTERS-1:0]  inhibit_q;
  logic [COUNTER_WIDTH-1:0] cnt_all [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0]  cnt_wr;
  logic                     accept;
  logic                     wr_en;
  logic                     addr_inh;
  logic [COUNTER_WIDTH-1:0] rd_data;
  logic                     rd_err;
`ifdef RSD_PERF_COUNTER_OVERFLOW_IRQ_EN
  logic                     addr_ovf;
  logic [NUM_COUNTERS-1:0]  wrap;
  logic [NUM_COUNTERS-1:0]  ovf_q;
  logic [NUM_COUNTERS-1:0]  ovf_d;
  logic [NUM_COUNTERS-1:0]  ovf_clr;
  logic                     irq_q;
`endif

  assign accept   = (state_q == IDLE) && csrReq;
  assign wr_en    = accept && csrWe;
  assign addr_inh = (csrAddr == ADDR_WIDTH'(NUM_COUNTERS));
`ifdef RSD_PERF_COUNTER_OVERFLOW_IRQ_EN
  assign addr_ovf = (csrAddr == ADDR_WIDTH'(NUM_COUNTERS + 1));
`endif

  for (genvar gi = 0; gi < NUM_COUNTERS; gi++) begin : g_cnt
    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic [COUNTER_WIDTH-1:0] cnt_d;
`ifdef RSD_PERF_COUNTER_OVERFLOW_IRQ_EN
    logic [COUNTER_WIDTH:0]   sum;
    assign sum      = {1'b0, cnt_q} + (COUNTER_WIDTH + 1)'(evCount[gi]);
    assign wrap[gi] = ~cnt_wr[gi] & ~inhibit_q[gi] & sum[COUNTER_WIDTH];
`else
    logic [COUNTER_WIDTH-1:0] sum;
    assign sum = cnt_q + COUNTER_WIDTH'(evCount[gi]);
`endif

    // A CSR write to this counter replaces the value and drops this cycle's events.
    assign cnt_wr[gi] = wr_en && (csrAddr == ADDR_WIDTH'(gi));
    assign cnt_d      = cnt_wr[gi]    ? csrWData :
                        inhibit_q[gi] ? cnt_q    : sum[COUNTER_WIDTH-1:0];

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_all[gi] = cnt_q;
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b1;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (csrAddr == ADDR_WIDTH'(i)) begin
        rd_data = cnt_all[i];
        rd_err  = 1'b0;
      end
    end
    if (addr_inh) begin
      rd_data = COUNTER_WIDTH'(inhibit_q);
      rd_err  = 1'b0;
    end
`ifdef RSD_PERF_COUNTER_OVERFLOW_IRQ_EN
    if (addr_ovf) begin
      rd_data = COUNTER_WIDTH'(ovf_q);
      rd_err  = 1'b0;
    end
`endif
  end

  // New inhibit mask only governs increments from the cycle after the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      inhibit_q <= '0;
    end else if (wr_en && addr_inh) begin
      inhibit_q <= csrWData[NUM_COUNTERS-1:0];
    end
  end

`ifdef RSD_PERF_COUNTER_OVERFLOW_IRQ_EN
  always_comb begin
    ovf_clr = cnt_wr;
    if (wr_en && addr_ovf) begin
      ovf_clr = ovf_clr | csrWData[NUM_COUNTERS-1:0];
    end
    ovf_d = (ovf_q & ~ovf_clr) | wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      irq_q <= |ovf_d;
    end
  end

  assign perfIrq = irq_q;
`else
  assign perfIrq = 1'b0;
`endif

  // Response registers are only non-zero during the single RESP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (csrReq) begin
            state_q <= RESP;
            ack_q   <= 1'b1;
            rdata_q <= csrWe ? '0 : rd_data;
            err_q   <= rd_err;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign csrAck   = ack_q;
  assign csrRData = rdata_q;
  assign csrErr   = err_q;

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Self-checking bench for perf_counter_ctrl: directed scenarios plus randomized traffic
// compared against an arithmetic reference model of counters, inhibit mask and overflow bits.
module tb_perf_counter_ctrl;
  localparam int NC = 4;
  localparam int CW = 64;
  localparam int EW = 2;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [EW-1:0] ev [NC];
  logic          csrReq = 1'b0;
  logic          csrWe = 1'b0;
  logic [AW-1:0] csrAddr = '0;
  logic [CW-1:0] csrWData = '0;
  logic          csrAck;
  logic [CW-1:0] csrRData;
  logic          csrErr;
  logic          perfIrq;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [CW-1:0] m_cnt [NC];
  logic [NC-1:0] m_inh = '0;
  logic [NC-1:0] m_ovf = '0;
  bit            m_resp = 1'b0;
  bit            m_ack = 1'b0;
  bit            m_err = 1'b0;
  bit            m_irq = 1'b0;
  logic [CW-1:0] m_rdata = '0;

  perf_counter_ctrl #(
    .NUM_COUNTERS (NC),
    .COUNTER_WIDTH(CW),
    .EVENT_WIDTH  (EW),
    .ADDR_WIDTH   (AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .evCount (ev),
    .csrReq  (csrReq),
    .csrWe   (csrWe),
    .csrAddr (csrAddr),
    .csrWData(csrWData),
    .csrAck  (csrAck),
    .csrRData(csrRData),
    .csrErr  (csrErr),
    .perfIrq (perfIrq)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock using the currently driven inputs, then advance the DUT.
  task automatic tick();
    int            a;
    bit            acc;
    bit            bad;
    logic [CW-1:0] rv;
    logic [CW:0]   s;
    logic [NC-1:0] nov;
    logic [NC-1:0] setb;
    a   = int'(csrAddr);
    acc = !m_resp && (csrReq === 1'b1);
    rv  = '0;
    bad = 1'b1;
    if (a < NC) begin
      rv = m_cnt[a]; bad = 1'b0;
    end else if (a == NC) begin
      rv = CW'(m_inh); bad = 1'b0;
    end
`ifdef RSD_PERF_COUNTER_OVERFLOW_IRQ_EN
    else if (a == NC + 1) begin
      rv = CW'(m_ovf); bad = 1'b0;
    end
`endif
    nov  = m_ovf;
    setb = '0;
    if (acc && csrWe && a == NC + 1 && !bad) nov = nov & ~csrWData[NC-1:0];
    for (int i = 0; i < NC; i++) begin
      if (acc && csrWe && a == i) begin
        m_cnt[i] = csrWData;
        nov[i]   = 1'b0;
      end else if (!m_inh[i]) begin
        s        = {1'b0, m_cnt[i]} + (CW + 1)'(ev[i]);
        m_cnt[i] = s[CW-1:0];
        setb[i]  = s[CW];
      end
    end
    nov = nov | setb;
    if (acc && csrWe && a == NC) m_inh = csrWData[NC-1:0];
`ifdef RSD_PERF_COUNTER_OVERFLOW_IRQ_EN
    m_ovf = nov;
    m_irq = |nov;
`else
    m_ovf = '0;
    m_irq = 1'b0;
`endif
    m_ack   = acc;
    m_err   = acc && bad;
    m_rdata = (acc && !csrWe) ? rv : '0;
    m_resp  = acc;
    if (acc && !rst) $display("txn %s addr=%0d wdata=%h", csrWe ? "wr" : "rd", a, csrWData);
    if (rst) begin
      for (int i = 0; i < NC; i++) m_cnt[i] = '0;
      m_inh = '0; m_ovf = '0; m_resp = 1'b0; m_ack = 1'b0;
      m_err = 1'b0; m_irq = 1'b0; m_rdata = '0;
    end
    @(posedge clk);
    #1;
  endtask

  // Present one request for the capture edge; returns positioned in the RESP cycle.
  task automatic csr_op(input bit we, input int addr, input logic [CW-1:0] wd);
    csrReq = 1'b1; csrWe = we; csrAddr = AW'(addr); csrWData = wd;
    tick();
    csrReq = 1'b0; csrWe = 1'b0; csrWData = '0;
  endtask

  task automatic zero_ev();
    for (int i = 0; i < NC; i++) ev[i] = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    zero_ev();
    tick();
    tick();
    checks++; if (csrAck !== 1'b0) begin errors++; $display("FAIL reset_ack got %0b want 0", csrAck); end
    checks++; if (csrRData !== '0) begin errors++; $display("FAIL reset_rdata got %h want 0", csrRData); end
    checks++; if (csrErr !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", csrErr); end
    checks++; if (perfIrq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b want 0", perfIrq); end
    rst = 1'b0;
  endtask

  task automatic test_accumulate();
    ev[0] = 2'd3;
    repeat (10) tick();
    ev[0] = 2'd0;
    csr_op(1'b0, 0, '0);
    checks++; if (csrAck !== 1'b1) begin errors++; $display("FAIL acc_ack got %0b want 1", csrAck); end
    checks++; if (csrRData !== 64'd30) begin errors++; $display("FAIL acc_rdata got %0d want 30", csrRData); end
    checks++; if (csrErr !== 1'b0) begin errors++; $display("FAIL acc_err got %0b want 0", csrErr); end
    checks++; if (csrRData !== m_rdata) begin errors++; $display("FAIL acc_model got %h want %h", csrRData, m_rdata); end
    tick();
  endtask

  task automatic test_write_vs_inc();
    ev[1] = 2'd2;
    csr_op(1'b1, 1, 64'h100);
    ev[1] = 2'd0;
    checks++; if (csrAck !== 1'b1 || csrErr !== 1'b0) begin errors++; $display("FAIL wr_ack got ack=%0b err=%0b want ack=1 err=0", csrAck, csrErr); end
    tick();
    csr_op(1'b0, 1, '0);
    checks++; if (csrRData !== 64'h100) begin errors++; $display("FAIL wr_drop_inc got %h want 100", csrRData); end
    tick();
  endtask

  task automatic test_inhibit();
    logic [CW-1:0] c0, c1;
    c0 = m_cnt[0];
    c1 = m_cnt[1];
    csr_op(1'b1, NC, 64'b0001);
    tick();
    ev[0] = 2'd1; ev[1] = 2'd1;
    repeat (5) tick();
    zero_ev();
    csr_op(1'b0, 0, '0);
    checks++; if (csrRData !== c0) begin errors++; $display("FAIL inh_cnt0 got %h want %h", csrRData, c0); end
    tick();
    csr_op(1'b0, 1, '0);
    checks++; if (csrRData !== c1 + 64'd5) begin errors++; $display("FAIL inh_cnt1 got %h want %h", csrRData, c1 + 64'd5); end
    tick();
    csr_op(1'b0, NC, '0);
    checks++; if (csrRData !== 64'd1) begin errors++; $display("FAIL inh_read got %h want 1", csrRData); end
    tick();
    csr_op(1'b1, NC, '0);
    tick();
  endtask

  task automatic test_invalid();
    logic [CW-1:0] snap [NC+1];
    csr_op(1'b0, 7, '0);
    checks++; if (csrAck !== 1'b1 || csrErr !== 1'b1) begin errors++; $display("FAIL inv_rd_flags got ack=%0b err=%0b want 1 1", csrAck, csrErr); end
    checks++; if (csrRData !== '0) begin errors++; $display("FAIL inv_rd_data got %h want 0", csrRData); end
    tick();
    csr_op(1'b0, NC + 1, '0);
    checks++; if (csrErr !== m_err || csrRData !== m_rdata) begin errors++; $display("FAIL addr5_rd got err=%0b data=%h want err=%0b data=%h", csrErr, csrRData, m_err, m_rdata); end
    tick();
    for (int i = 0; i < NC; i++) snap[i] = m_cnt[i];
    snap[NC] = CW'(m_inh);
    csr_op(1'b1, 7, {$urandom, $urandom});
    checks++; if (csrErr !== 1'b1) begin errors++; $display("FAIL inv_wr_err got %0b want 1", csrErr); end
    tick();
    for (int i = 0; i <= NC; i++) begin
      csr_op(1'b0, i, '0);
      checks++; if (csrRData !== snap[i]) begin errors++; $display("FAIL inv_wr_keep%0d got %h want %h", i, csrRData, snap[i]); end
      tick();
    end
  endtask

  task automatic test_overflow();
    bit irq_exp;
`ifdef RSD_PERF_COUNTER_OVERFLOW_IRQ_EN
    irq_exp = 1'b1;
`else
    irq_exp = 1'b0;
`endif
    zero_ev();
    csr_op(1'b1, 2, {CW{1'b1}});
    ev[2] = 2'd2;
    tick();
    ev[2] = 2'd0;
    checks++; if (perfIrq !== irq_exp) begin errors++; $display("FAIL ovf_irq got %0b want %0b", perfIrq, irq_exp); end
    checks++; if (perfIrq !== m_irq) begin errors++; $display("FAIL ovf_irq_model got %0b want %0b", perfIrq, m_irq); end
    csr_op(1'b0, 2, '0);
    checks++; if (csrRData !== 64'd1) begin errors++; $display("FAIL ovf_wrap got %h want 1", csrRData); end
    tick();
    csr_op(1'b1, NC + 1, 64'b0100);
    checks++; if (perfIrq !== 1'b0) begin errors++; $display("FAIL ovf_w1c got %0b want 0", perfIrq); end
    tick();
  endtask

  task automatic test_back_to_back();
    csrReq = 1'b1; csrWe = 1'b0;
    for (int k = 0; k < 8; k++) begin
      csrAddr = AW'(k % NC);
      tick();
      checks++; if (csrAck !== ((k % 2) == 0)) begin errors++; $display("FAIL b2b_ack%0d got %0b want %0b", k, csrAck, (k % 2) == 0); end
      checks++; if (csrRData !== m_rdata) begin errors++; $display("FAIL b2b_data%0d got %h want %h", k, csrRData, m_rdata); end
    end
    csrReq = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_resp();
    for (int i = 0; i < NC; i++) ev[i] = 2'd3;
    repeat (4) tick();
    zero_ev();
    csr_op(1'b0, 0, '0);
    checks++; if (csrAck !== 1'b1) begin errors++; $display("FAIL rir_ack_pre got %0b want 1", csrAck); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (csrAck !== 1'b0 || csrRData !== '0) begin errors++; $display("FAIL rir_ack got ack=%0b data=%h want 0 0", csrAck, csrRData); end
    for (int i = 0; i < NC; i++) begin
      csr_op(1'b0, i, '0);
      checks++; if (csrRData !== '0) begin errors++; $display("FAIL rir_cnt%0d got %h want 0", i, csrRData); end
      tick();
    end
    rst = 1'b1; csrReq = 1'b1; csrWe = 1'b1; csrAddr = '0; csrWData = 64'h77;
    tick();
    rst = 1'b0; csrReq = 1'b0; csrWe = 1'b0;
    checks++; if (csrAck !== 1'b0) begin errors++; $display("FAIL rcap_ack got %0b want 0", csrAck); end
    tick();
    csr_op(1'b0, 0, '0);
    checks++; if (csrRData !== '0) begin errors++; $display("FAIL rcap_discard got %h want 0", csrRData); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NC; i++) ev[i] = EW'($urandom);
      rst      = ($urandom_range(0, 63) == 0);
      csrReq   = 1'($urandom_range(0, 1));
      csrWe    = 1'($urandom_range(0, 1));
      csrAddr  = AW'($urandom);
      csrWData = ($urandom_range(0, 3) == 0) ? ~CW'($urandom_range(0, 8)) : {$urandom, $urandom};
      tick();
      checks++; if (csrAck !== m_ack) begin errors++; $display("FAIL rnd_ack n=%0d got %0b want %0b", n, csrAck, m_ack); end
      checks++; if (csrRData !== m_rdata) begin errors++; $display("FAIL rnd_data n=%0d got %h want %h", n, csrRData, m_rdata); end
      checks++; if (csrErr !== m_err) begin errors++; $display("FAIL rnd_err n=%0d got %0b want %0b", n, csrErr, m_err); end
      checks++; if (perfIrq !== m_irq) begin errors++; $display("FAIL rnd_irq n=%0d got %0b want %0b", n, perfIrq, m_irq); end
    end
    rst = 1'b0; csrReq = 1'b0; csrWe = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    zero_ev();
    for (int i = 0; i < NC; i++) m_cnt[i] = '0;
    test_reset();
    test_accumulate();
    test_write_vs_inc();
    test_inhibit();
    test_invalid();
    test_overflow();
    test_back_to_back();
    test_reset_in_resp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
